hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller driving the select of the ID/EX control-signal NOP mux (ctrlsig), the PC write enable and the IF/ID write/flush enables.
- Detects load-use hazards and inserts a parameterised number of bubbles.
- Squashes wrong-path instructions after a taken branch or jump resolved in MEM.
- Freezes the pipeline permanently once a fin instruction reaches EX.

Parameters:
LOAD_STALL, 1, bubble cycles inserted per load-use hazard (1..7)
BRANCH_FLUSH, 1, cycles IF/ID and ID/EX are squashed after a taken branch or jump (1..7)
CNT_W, 16, width of the saturating bubble counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
idex_memrd  in  1  instruction in EX is a load
idex_rt  in  5  destination register of the load in EX
ifid_rs  in  5  rs field of the instruction in ID
ifid_rt  in  5  rt field of the instruction in ID
ifid_uses_rt  in  1  instruction in ID reads rt as a source
redirect  in  1  taken branch or jump resolved in MEM this cycle
idex_fin  in  1  fin control bit of the instruction in EX
ctrlsig  out  1  1 = ID/EX receives NOP control signals
pcwrite  out  1  PC register write enable
ifidwrite  out  1  IF/ID write enable
ifidflush  out  1  IF/ID cleared to NOP on next edge
exflush  out  1  EX/MEM control bits cleared (kills instruction in EX)
halted  out  1  pipeline frozen by fin
bubble_cnt  out  CNT_W  saturating count of bubble cycles

Behaviour:
- FSM states: RUN, STALL, FLUSH, HALT. Down-counter cnt is 3 bits.
- While rst=1:
  - state=RUN, cnt=0, bubble_cnt=0.
  - Outputs forced to ctrlsig=1, pcwrite=0, ifidwrite=0, ifidflush=1, exflush=1, halted=0.
- Hazard term: hz = idex_memrd & (idex_rt!=0) & ((idex_rt==ifid_rs) | (ifid_uses_rt & idex_rt==ifid_rt)). Register 0 never creates a hazard.
- Priority in RUN, STALL and FLUSH: redirect > idex_fin > hz.
- RUN:
  - redirect:
    - Outputs: ctrlsig=1, ifidflush=1, exflush=1, pcwrite=1, ifidwrite=1.
    - If BRANCH_FLUSH>1, next=FLUSH with cnt=BRANCH_FLUSH-1; else stay in RUN.
  - idex_fin (no redirect): ctrlsig=1, pcwrite=0, ifidwrite=0; next=HALT.
  - hz: ctrlsig=1, pcwrite=0, ifidwrite=0 in the same cycle (combinational, zero latency).
    - If LOAD_STALL>1, next=STALL with cnt=LOAD_STALL-1; else stay in RUN.
  - none of the above: ctrlsig=0, pcwrite=1, ifidwrite=1, flushes=0.
- STALL:
  - Outputs as hz in RUN; cnt decrements each cycle.
  - Exit to RUN on the cycle cnt==1; ID instruction issues normally on the following cycle.
  - redirect aborts the stall: outputs and next state as redirect in RUN. The load is wrong-path.
  - idex_fin is not re-evaluated. EX holds a bubble.
- FLUSH:
  - Outputs: ctrlsig=1, ifidflush=1, exflush=0, pcwrite=1, ifidwrite=1.
  - cnt decrements; exit to RUN when cnt==1.
  - A new redirect reloads cnt=BRANCH_FLUSH-1 and asserts exflush that cycle.
- HALT:
  - Outputs: ctrlsig=1, pcwrite=0, ifidwrite=0, flushes=0, halted=1.
  - Inputs ignored; only rst exits.
- bubble_cnt:
  - Increments on every clock where ctrlsig=1, state!=HALT and rst=0.
  - Saturates at all-ones.
- Total bubbles per isolated load-use = LOAD_STALL. Total squashed fetch cycles per redirect = BRANCH_FLUSH.
- All outputs are combinational from state, cnt and inputs; state, cnt and bubble_cnt are registered.

Test Plan:
- Reset with all inputs 0, then release:
  - during rst, ctrlsig=1, pcwrite=0, ifidflush=1;
  - first cycle after release, ctrlsig=0, pcwrite=1, bubble_cnt=0.
- LOAD_STALL=1: idex_memrd=1, idex_rt=5, ifid_rs=5 for one cycle -> ctrlsig=1, pcwrite=0, ifidwrite=0 that cycle only; bubble_cnt=1.
- Load hazard filtering:
  - idex_rt=0, ifid_rs=0, idex_memrd=1 -> no stall.
  - idex_rt=7, ifid_rt=7, ifid_uses_rt=0 -> no stall.
  - Same with ifid_uses_rt=1 -> stall.
- LOAD_STALL=3, hazard, then redirect=1 on the second stall cycle:
  - that cycle: ifidflush=1, exflush=1, pcwrite=1;
  - next cycle: RUN with ctrlsig=0; bubble_cnt=2.
- BRANCH_FLUSH=2, redirect with idex_fin=1 and hz=1 same cycle:
  - cycle 0: redirect response;
  - cycle 1: ifidflush=1, exflush=0;
  - cycle 2: RUN; halted stays 0.
- idex_fin=1 in RUN -> halted=1 from next cycle, pcwrite=0 held for 20 cycles despite hz/redirect toggling; bubble_cnt frozen; rst clears halted.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch/jump squash and fin freeze.
// Drives the ID/EX NOP-mux select, PC write enable and IF/ID write/flush enables.
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL   = 1,
  parameter int unsigned BRANCH_FLUSH = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             idex_memrd,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             redirect,
  input  logic             idex_fin,
  output logic             ctrlsig,
  output logic             pcwrite,
  output logic             ifidwrite,
  output logic             ifidflush,
  output logic             exflush,
  output logic             halted,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] LS_RELOAD = CW'(LOAD_STALL - 1);
  localparam logic [CW-1:0] BF_RELOAD = CW'(BRANCH_FLUSH - 1);

  typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          hz;
  logic          take_redirect;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  always_comb begin
    hz = idex_memrd && (idex_rt != 5'd0) &&
         ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  end

  assign take_redirect = redirect && (state != HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ctrlsig   = 1'b0;
    pcwrite   = 1'b1;
    ifidwrite = 1'b1;
    ifidflush = 1'b0;
    exflush   = 1'b0;
    halted    = 1'b0;

    if (rst) begin
      ctrlsig   = 1'b1;
      pcwrite   = 1'b0;
      ifidwrite = 1'b0;
      ifidflush = 1'b1;
      exflush   = 1'b1;
    end else if (take_redirect) begin
      // Wrong-path work in IF, ID and EX is killed; fetch resumes at the target.
      ctrlsig   = 1'b1;
      ifidflush = 1'b1;
      exflush   = 1'b1;
      if (BRANCH_FLUSH > 1) begin
        state_n = FLUSH;
        cnt_n   = BF_RELOAD;
      end else begin
        state_n = RUN;
        cnt_n   = '0;
      end
    end else begin
      case (state)
        RUN: begin
          if (idex_fin) begin
            ctrlsig   = 1'b1;
            pcwrite   = 1'b0;
            ifidwrite = 1'b0;
            state_n   = HALT;
          end else if (hz) begin
            ctrlsig   = 1'b1;
            pcwrite   = 1'b0;
            ifidwrite = 1'b0;
            if (LOAD_STALL > 1) begin
              state_n = STALL;
              cnt_n   = LS_RELOAD;
            end
          end
        end
        STALL: begin
          ctrlsig   = 1'b1;
          pcwrite   = 1'b0;
          ifidwrite = 1'b0;
          cnt_n     = cnt - CW'(1);
          if (cnt == CW'(1)) state_n = RUN;
        end
        FLUSH: begin
          ctrlsig   = 1'b1;
          ifidflush = 1'b1;
          cnt_n     = cnt - CW'(1);
          if (cnt == CW'(1)) state_n = RUN;
        end
        HALT: begin
          ctrlsig   = 1'b1;
          pcwrite   = 1'b0;
          ifidwrite = 1'b0;
          halted    = 1'b1;
        end
        default: state_n = RUN;
      endcase
    end
  end

  // Saturating count of bubble cycles; frozen once halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (ctrlsig && (state != HALT) && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: four parameterisations share one input set,
// expectations are queued at drive time and compared mid-cycle.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       idex_memrd, ifid_uses_rt, redirect, idex_fin;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;

  logic ctrlsig [4];
  logic pcwrite [4];
  logic ifidwrite [4];
  logic ifidflush [4];
  logic exflush [4];
  logic halted [4];
  logic [15:0] bc0, bc1, bc2;
  logic [1:0]  bc3;

  // {ctrlsig, pcwrite, ifidwrite, ifidflush, exflush, halted}
  localparam logic [5:0] O_RST   = 6'b100110;
  localparam logic [5:0] O_RUN   = 6'b011000;
  localparam logic [5:0] O_STALL = 6'b100000;
  localparam logic [5:0] O_RED   = 6'b111110;
  localparam logic [5:0] O_FLUSH = 6'b111100;
  localparam logic [5:0] O_HALT  = 6'b100001;

  typedef struct {
    string      tag;
    int         sel;
    logic [5:0] o;
    int         bc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL(1), .BRANCH_FLUSH(1), .CNT_W(16)) u_ls1 (
    .clk(clk), .rst(rst), .idex_memrd(idex_memrd), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .redirect(redirect), .idex_fin(idex_fin), .ctrlsig(ctrlsig[0]),
    .pcwrite(pcwrite[0]), .ifidwrite(ifidwrite[0]), .ifidflush(ifidflush[0]),
    .exflush(exflush[0]), .halted(halted[0]), .bubble_cnt(bc0));

  hazard_ctrl #(.LOAD_STALL(3), .BRANCH_FLUSH(1), .CNT_W(16)) u_ls3 (
    .clk(clk), .rst(rst), .idex_memrd(idex_memrd), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .redirect(redirect), .idex_fin(idex_fin), .ctrlsig(ctrlsig[1]),
    .pcwrite(pcwrite[1]), .ifidwrite(ifidwrite[1]), .ifidflush(ifidflush[1]),
    .exflush(exflush[1]), .halted(halted[1]), .bubble_cnt(bc1));

  hazard_ctrl #(.LOAD_STALL(1), .BRANCH_FLUSH(2), .CNT_W(16)) u_bf2 (
    .clk(clk), .rst(rst), .idex_memrd(idex_memrd), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .redirect(redirect), .idex_fin(idex_fin), .ctrlsig(ctrlsig[2]),
    .pcwrite(pcwrite[2]), .ifidwrite(ifidwrite[2]), .ifidflush(ifidflush[2]),
    .exflush(exflush[2]), .halted(halted[2]), .bubble_cnt(bc2));

  hazard_ctrl #(.LOAD_STALL(1), .BRANCH_FLUSH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .idex_memrd(idex_memrd), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .redirect(redirect), .idex_fin(idex_fin), .ctrlsig(ctrlsig[3]),
    .pcwrite(pcwrite[3]), .ifidwrite(ifidwrite[3]), .ifidflush(ifidflush[3]),
    .exflush(exflush[3]), .halted(halted[3]), .bubble_cnt(bc3));

  function automatic logic [5:0] obs_o(int s);
    return {ctrlsig[s], pcwrite[s], ifidwrite[s], ifidflush[s], exflush[s], halted[s]};
  endfunction

  function automatic int obs_bc(int s);
    case (s)
      0:       return int'(bc0);
      1:       return int'(bc1);
      2:       return int'(bc2);
      default: return int'(bc3);
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [5:0] o, input int bc);
    exp_t e;
    e.tag = tag; e.sel = sel; e.o = o; e.bc = bc;
    sb.push_back(e);
  endtask

  task automatic check_queue();
    exp_t e;
    logic [5:0] got_o;
    int got_bc;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got_o = obs_o(e.sel);
      total++;
      assert (got_o === e.o) passed++;
      else $error("FAIL %s outs[dut%0d]: observed %b expected %b", e.tag, e.sel, got_o, e.o);
      if (e.bc >= 0) begin
        got_bc = obs_bc(e.sel);
        total++;
        assert (got_bc === e.bc) passed++;
        else $error("FAIL %s bubble_cnt[dut%0d]: observed %0d expected %0d", e.tag, e.sel, got_bc, e.bc);
      end
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are compared mid-cycle.
  task automatic tick();
    #4;
    check_queue();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic memrd, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic uses, input logic red, input logic fin);
    idex_memrd = memrd; idex_rt = ert; ifid_rs = rs; ifid_rt = rt;
    ifid_uses_rt = uses; redirect = red; idex_fin = fin;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int s = 0; s < 4; s++) expect_out("reset", s, O_RST, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) expect_out("in_reset", s, O_RST, 0);
    tick();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) expect_out("after_reset", s, O_RUN, 0);
    tick();

    // Single-bubble load-use, then hazard filtering.
    set_in(1, 5, 5, 0, 0, 0, 0); expect_out("ls1_hz", 0, O_STALL, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); expect_out("ls1_resume", 0, O_RUN, 1); tick();
    set_in(1, 0, 0, 0, 0, 0, 0); expect_out("r0_nohz", 0, O_RUN, 1); tick();
    set_in(1, 7, 0, 7, 0, 0, 0); expect_out("rt_unused", 0, O_RUN, 1); tick();
    set_in(0, 7, 7, 7, 1, 0, 0); expect_out("not_load", 0, O_RUN, 1); tick();
    set_in(1, 7, 0, 7, 1, 0, 0); expect_out("rt_used", 0, O_STALL, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); expect_out("rt_resume", 0, O_RUN, 2); tick();

    // Three-bubble stall runs to completion; fin during the stall is ignored.
    do_reset();
    set_in(1, 9, 9, 0, 0, 0, 0); expect_out("ls3_hz", 1, O_STALL, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 1); expect_out("ls3_st1_fin", 1, O_STALL, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); expect_out("ls3_st2", 1, O_STALL, 2); tick();
    expect_out("ls3_exit", 1, O_RUN, 3); tick();
    expect_out("ls3_run", 1, O_RUN, 3); tick();

    // Redirect aborts the stall on its second cycle.
    do_reset();
    set_in(1, 9, 9, 0, 0, 0, 0); expect_out("ls3b_hz", 1, O_STALL, 0); tick();
    set_in(0, 0, 0, 0, 0, 1, 0); expect_out("ls3b_redir", 1, O_RED, 1); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); expect_out("ls3b_run", 1, O_RUN, 2); tick();

    // Two-cycle flush: redirect beats fin and hazard in the same cycle.
    do_reset();
    set_in(1, 4, 4, 0, 0, 1, 1); expect_out("bf2_redir", 2, O_RED, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); expect_out("bf2_flush", 2, O_FLUSH, 1); tick();
    expect_out("bf2_run", 2, O_RUN, 2); tick();
    expect_out("bf2_run2", 2, O_RUN, 2); tick();
    // A second redirect during the flush reloads it.
    set_in(0, 0, 0, 0, 0, 1, 0); expect_out("bf2_r1", 2, O_RED, 2); tick();
    expect_out("bf2_r2", 2, O_RED, 3); tick();
    set_in(0, 0, 0, 0, 0, 0, 0); expect_out("bf2_fl2", 2, O_FLUSH, 4); tick();
    expect_out("bf2_run3", 2, O_RUN, 5); tick();

    // Bubble counter saturates at all-ones.
    do_reset();
    set_in(1, 3, 3, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      expect_out("sat", 3, O_STALL, (i > 3) ? 3 : i);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0); expect_out("sat_run", 3, O_RUN, 3); tick();

    // fin freezes the pipeline until reset.
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1); expect_out("fin", 0, O_STALL, 0); tick();
    for (int i = 0; i < 20; i++) begin
      set_in(logic'(i % 2), 5, 5, 0, 0, logic'(i % 3 == 0), logic'(i % 2));
      expect_out("halt", 0, O_HALT, 1);
      tick();
    end
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    expect_out("halt_rst", 0, O_RST, 0); tick();
    rst = 1'b0;
    expect_out("halt_cleared", 0, O_RUN, 0); tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
